// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: RV32 subset decoder (LW, SW, R/I ALU, LUI, BEQ, BNE, JAL,
// JALR) feeding a registered ID/EX control stage, with load-use stall and
// bubble insertion.
// Build option: define CTRL_MULDIV_EN to decode MUL and stall the front end
// for MUL_LAT-1 cycles after issue while ID/EX holds the multiply.
module decode_ctrl_pipe #(
  parameter int MUL_LAT   = 4,
  parameter int ALUCTRL_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 id_valid,
  input  logic                 flush,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [ALUCTRL_W-1:0] ex_aluctrl,
  output logic                 ex_alusrc,
  output logic [2:0]           ex_immsrc,
  output logic                 ex_regwrite,
  output logic                 ex_memwrite,
  output logic [1:0]           ex_resultsrc,
  output logic [1:0]           ex_brtype,
  output logic                 ex_jalr,
  output logic [4:0]           ex_rd,
  output logic                 ex_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR  = 4'd3,
    ALU_XOR   = 4'd4,  ALU_SLT  = 4'd5,  ALU_SLTU = 4'd6,  ALU_SLL = 4'd7,
    ALU_SRL   = 4'd8,  ALU_SRA  = 4'd9,  ALU_PASSB = 4'd10, ALU_PC4 = 4'd11,
    ALU_MUL   = 4'd12
  } alu_op_t;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_sel_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10
  } res_sel_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00, BR_EQ = 2'b01, BR_NE = 2'b10, BR_JUMP = 2'b11
  } br_type_t;

  // Elaboration-time guard on parameter ranges.
  if (MUL_LAT < 1 || MUL_LAT > 16 || ALUCTRL_W < 4) begin : g_param_check
    $error("decode_ctrl_pipe: MUL_LAT must be 1..16 and ALUCTRL_W >= 4");
  end

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // funct3 -> ALU op; alt is funct7[5], sub_ok allows SUB (R-type only).
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt,
                                          input logic sub_ok);
    alu_op_t op;
    op = ALU_ADD;
    case (f3)
      3'b000: if (alt && sub_ok) op = ALU_SUB; else op = ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: if (alt) op = ALU_SRA; else op = ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic     d_legal, d_alusrc, d_regwrite, d_memwrite, d_jalr;
  logic     use_rs1, use_rs2;
  alu_op_t  d_alu;
  imm_sel_t d_imm;
  res_sel_t d_res;
  br_type_t d_br;
`ifdef CTRL_MULDIV_EN
  logic     d_mul;
`endif

  // Instruction decode of the ID-stage word.
  always_comb begin
    d_legal    = 1'b0;
    d_alu      = ALU_ADD;
    d_alusrc   = 1'b0;
    d_imm      = IMM_I;
    d_regwrite = 1'b0;
    d_memwrite = 1'b0;
    d_res      = RES_ALU;
    d_br       = BR_NONE;
    d_jalr     = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
`ifdef CTRL_MULDIV_EN
    d_mul      = 1'b0;
`endif
    case (opcode)
      OP_LOAD: if (funct3 == 3'b010) begin
        d_legal    = 1'b1;
        d_alusrc   = 1'b1;
        d_regwrite = 1'b1;
        d_res      = RES_MEM;
        use_rs1    = 1'b1;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        d_legal    = 1'b1;
        d_alusrc   = 1'b1;
        d_imm      = IMM_S;
        d_memwrite = 1'b1;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_RTYPE: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          d_legal = 1'b1;
          d_alu   = alu_from_f3(funct3, funct7[5], 1'b1);
`ifdef CTRL_MULDIV_EN
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          d_legal = 1'b1;
          d_alu   = ALU_MUL;
          d_mul   = 1'b1;
`endif
        end
        d_regwrite = d_legal;
        use_rs1    = d_legal;
        use_rs2    = d_legal;
      end
      OP_ITYPE: begin
        d_legal    = 1'b1;
        d_alu      = alu_from_f3(funct3, funct7[5], 1'b0);
        d_alusrc   = 1'b1;
        d_regwrite = 1'b1;
        use_rs1    = 1'b1;
      end
      OP_LUI: begin
        d_legal    = 1'b1;
        d_alu      = ALU_PASSB;
        d_alusrc   = 1'b1;
        d_imm      = IMM_U;
        d_regwrite = 1'b1;
      end
      OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) begin
        d_legal = 1'b1;
        d_alu   = ALU_SUB;
        d_imm   = IMM_B;
        if (funct3[0]) d_br = BR_NE; else d_br = BR_EQ;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        d_legal    = 1'b1;
        d_alu      = ALU_PC4;
        d_imm      = IMM_J;
        d_regwrite = 1'b1;
        d_res      = RES_PC4;
        d_br       = BR_JUMP;
      end
      OP_JALR: if (funct3 == 3'b000) begin
        d_legal    = 1'b1;
        d_alusrc   = 1'b1;
        d_regwrite = 1'b1;
        d_res      = RES_PC4;
        d_br       = BR_JUMP;
        d_jalr     = 1'b1;
        use_rs1    = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
  end

  logic lu_hazard, mul_busy;

  // Load in EX whose destination is read by the ID instruction.
  always_comb begin
    lu_hazard = ex_valid && (ex_resultsrc == RES_MEM) && (ex_rd != 5'd0) && id_valid &&
                ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));
  end

  assign stall = !rst && !flush && (lu_hazard || mul_busy);

`ifdef CTRL_MULDIV_EN
  localparam logic [4:0] MUL_INIT = 5'(MUL_LAT - 1);
  logic [4:0] mul_cnt;

  // Multiply busy counter: loaded on MUL issue, counts down to idle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mul_cnt <= '0;
    end else if (mul_cnt != '0) begin
      mul_cnt <= mul_cnt - 5'd1;
    end else if (!lu_hazard && id_valid && d_legal && d_mul) begin
      mul_cnt <= MUL_INIT;
    end
  end

  assign mul_busy = (mul_cnt != '0);
`else
  assign mul_busy = 1'b0;
`endif

  logic     nxt_valid, nxt_alusrc, nxt_regwrite, nxt_memwrite, nxt_jalr, nxt_illegal;
  alu_op_t  nxt_alu;
  imm_sel_t nxt_imm;
  res_sel_t nxt_res;
  br_type_t nxt_br;
  logic [4:0] nxt_rd;

  // Next ID/EX contents: decoded instruction, or a bubble on hazard/invalid/illegal.
  always_comb begin
    nxt_valid    = 1'b0;
    nxt_alu      = ALU_ADD;
    nxt_alusrc   = 1'b0;
    nxt_imm      = IMM_I;
    nxt_regwrite = 1'b0;
    nxt_memwrite = 1'b0;
    nxt_res      = RES_ALU;
    nxt_br       = BR_NONE;
    nxt_jalr     = 1'b0;
    nxt_rd       = '0;
    nxt_illegal  = 1'b0;
    if (lu_hazard) begin
      nxt_valid = 1'b0;
    end else if (id_valid && d_legal) begin
      nxt_valid    = 1'b1;
      nxt_alu      = d_alu;
      nxt_alusrc   = d_alusrc;
      nxt_imm      = d_imm;
      nxt_regwrite = d_regwrite;
      nxt_memwrite = d_memwrite;
      nxt_res      = d_res;
      nxt_br       = d_br;
      nxt_jalr     = d_jalr;
      nxt_rd       = d_regwrite ? rd : 5'd0;
    end else begin
      nxt_illegal  = id_valid;
    end
  end

  // ID/EX register: reset/flush clear, multiply busy holds, otherwise load.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_valid     <= 1'b0;
      ex_aluctrl   <= '0;
      ex_alusrc    <= 1'b0;
      ex_immsrc    <= '0;
      ex_regwrite  <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_resultsrc <= '0;
      ex_brtype    <= '0;
      ex_jalr      <= 1'b0;
      ex_rd        <= '0;
      ex_illegal   <= 1'b0;
    end else if (!mul_busy) begin
      ex_valid     <= nxt_valid;
      ex_aluctrl   <= ALUCTRL_W'(nxt_alu);
      ex_alusrc    <= nxt_alusrc;
      ex_immsrc    <= nxt_imm;
      ex_regwrite  <= nxt_regwrite;
      ex_memwrite  <= nxt_memwrite;
      ex_resultsrc <= nxt_res;
      ex_brtype    <= nxt_br;
      ex_jalr      <= nxt_jalr;
      ex_rd        <= nxt_rd;
      ex_illegal   <= nxt_illegal;
    end
  end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Testbench for decode_ctrl_pipe: instructions are built from their meaning
// (with the expected control word), a reference pipeline model predicts stall
// and ID/EX contents, and expectations flow through a scoreboard queue.
module tb_decode_ctrl_pipe;

  localparam int MUL_LAT = 4;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_XOR = 4'd4, A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7,
                         A_SRL = 4'd8, A_SRA = 4'd9, A_PASSB = 4'd10, A_PC4 = 4'd11,
                         A_MUL = 4'd12;

  typedef struct packed {
    logic       v;
    logic [3:0] alu;
    logic       asrc;
    logic [2:0] imm;
    logic       rw;
    logic       mw;
    logic [1:0] res;
    logic [1:0] br;
    logic       jalr;
    logic [4:0] rd;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    logic [31:0] ins;
    ctl_t        c;
    logic        u1;
    logic        u2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        mul;
  } item_t;

  logic        clk = 1'b0;
  logic        rst, id_valid, flush;
  logic [31:0] instr;
  logic        stall, ex_valid, ex_alusrc, ex_regwrite, ex_memwrite, ex_jalr, ex_illegal;
  logic [3:0]  ex_aluctrl;
  logic [2:0]  ex_immsrc;
  logic [1:0]  ex_resultsrc, ex_brtype;
  logic [4:0]  ex_rd;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  ctl_t        m_ex;
  int unsigned m_cnt;
  ctl_t        sb[$];
  ctl_t        dut_c;

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.MUL_LAT(MUL_LAT), .ALUCTRL_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_aluctrl(ex_aluctrl), .ex_alusrc(ex_alusrc),
    .ex_immsrc(ex_immsrc), .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite),
    .ex_resultsrc(ex_resultsrc), .ex_brtype(ex_brtype), .ex_jalr(ex_jalr),
    .ex_rd(ex_rd), .ex_illegal(ex_illegal)
  );

  always_comb begin
    dut_c      = '0;
    dut_c.v    = ex_valid;
    dut_c.alu  = ex_aluctrl;
    dut_c.asrc = ex_alusrc;
    dut_c.imm  = ex_immsrc;
    dut_c.rw   = ex_regwrite;
    dut_c.mw   = ex_memwrite;
    dut_c.res  = ex_resultsrc;
    dut_c.br   = ex_brtype;
    dut_c.jalr = ex_jalr;
    dut_c.rd   = ex_rd;
    dut_c.ill  = ex_illegal;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- instruction builders ----
  function automatic logic [2:0] f3_of(input logic [3:0] op);
    case (op)
      A_SLL:         return 3'b001;
      A_SLT:         return 3'b010;
      A_SLTU:        return 3'b011;
      A_XOR:         return 3'b100;
      A_SRL, A_SRA:  return 3'b101;
      A_OR:          return 3'b110;
      A_AND:         return 3'b111;
      default:       return 3'b000;
    endcase
  endfunction

  function automatic item_t mk_r(input logic [3:0] op, input logic [4:0] rd, rs1, rs2);
    item_t it;
    logic [6:0] f7;
    f7 = (op == A_SUB || op == A_SRA) ? 7'b0100000 : 7'b0000000;
    it = '0;
    it.ins = {f7, rs2, rs1, f3_of(op), rd, 7'b0110011};
    it.c.v = 1'b1; it.c.alu = op; it.c.rw = 1'b1; it.c.rd = rd;
    it.u1 = 1'b1; it.u2 = 1'b1; it.rs1 = rs1; it.rs2 = rs2;
    return it;
  endfunction

  function automatic item_t mk_i(input logic [3:0] op, input logic [4:0] rd, rs1,
                                 input logic [11:0] imm);
    item_t it;
    logic [11:0] im;
    im = imm;
    if (op == A_SRA) im = {7'b0100000, imm[4:0]};
    else if (op == A_SLL || op == A_SRL) im = {7'b0000000, imm[4:0]};
    it = '0;
    it.ins = {im, rs1, f3_of(op), rd, 7'b0010011};
    it.c.v = 1'b1; it.c.alu = op; it.c.asrc = 1'b1; it.c.rw = 1'b1; it.c.rd = rd;
    it.u1 = 1'b1; it.rs1 = rs1;
    return it;
  endfunction

  function automatic item_t mk_lw(input logic [4:0] rd, rs1, input logic [11:0] off);
    item_t it;
    it = '0;
    it.ins = {off, rs1, 3'b010, rd, 7'b0000011};
    it.c.v = 1'b1; it.c.asrc = 1'b1; it.c.rw = 1'b1; it.c.res = 2'b01; it.c.rd = rd;
    it.u1 = 1'b1; it.rs1 = rs1;
    return it;
  endfunction

  function automatic item_t mk_sw(input logic [4:0] rs2, rs1, input logic [11:0] off);
    item_t it;
    it = '0;
    it.ins = {off[11:5], rs2, rs1, 3'b010, off[4:0], 7'b0100011};
    it.c.v = 1'b1; it.c.asrc = 1'b1; it.c.imm = 3'b001; it.c.mw = 1'b1;
    it.u1 = 1'b1; it.u2 = 1'b1; it.rs1 = rs1; it.rs2 = rs2;
    return it;
  endfunction

  function automatic item_t mk_lui(input logic [4:0] rd, input logic [19:0] imm);
    item_t it;
    it = '0;
    it.ins = {imm, rd, 7'b0110111};
    it.c.v = 1'b1; it.c.alu = A_PASSB; it.c.asrc = 1'b1; it.c.imm = 3'b100;
    it.c.rw = 1'b1; it.c.rd = rd;
    return it;
  endfunction

  function automatic item_t mk_br(input logic ne, input logic [4:0] rs1, rs2);
    item_t it;
    it = '0;
    it.ins = {7'b0, rs2, rs1, {2'b00, ne}, 5'b0, 7'b1100011};
    it.c.v = 1'b1; it.c.alu = A_SUB; it.c.imm = 3'b010; it.c.br = ne ? 2'b10 : 2'b01;
    it.u1 = 1'b1; it.u2 = 1'b1; it.rs1 = rs1; it.rs2 = rs2;
    return it;
  endfunction

  function automatic item_t mk_jal(input logic [4:0] rd, input logic [19:0] imm);
    item_t it;
    it = '0;
    it.ins = {imm, rd, 7'b1101111};
    it.c.v = 1'b1; it.c.alu = A_PC4; it.c.imm = 3'b011; it.c.rw = 1'b1;
    it.c.res = 2'b10; it.c.br = 2'b11; it.c.rd = rd;
    return it;
  endfunction

  function automatic item_t mk_jalr(input logic [4:0] rd, rs1, input logic [11:0] off);
    item_t it;
    it = '0;
    it.ins = {off, rs1, 3'b000, rd, 7'b1100111};
    it.c.v = 1'b1; it.c.asrc = 1'b1; it.c.rw = 1'b1; it.c.res = 2'b10;
    it.c.br = 2'b11; it.c.jalr = 1'b1; it.c.rd = rd;
    it.u1 = 1'b1; it.rs1 = rs1;
    return it;
  endfunction

  function automatic item_t mk_bad(input logic [31:0] ins);
    item_t it;
    it = '0;
    it.ins = ins;
    it.c.ill = 1'b1;
    return it;
  endfunction

  function automatic item_t mk_mul(input logic [4:0] rd, rs1, rs2);
    item_t it;
    it = '0;
    it.ins = {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011};
`ifdef CTRL_MULDIV_EN
    it.c.v = 1'b1; it.c.alu = A_MUL; it.c.rw = 1'b1; it.c.rd = rd;
    it.u1 = 1'b1; it.u2 = 1'b1; it.rs1 = rs1; it.rs2 = rs2; it.mul = 1'b1;
`else
    it.c.ill = 1'b1;
`endif
    return it;
  endfunction

  // One clock: drive, check stall, predict next ID/EX, compare after the edge.
  task automatic step(input item_t it, input logic idv, input logic fl, input logic rs,
                      input string tag, output logic stl);
    logic lu;
    ctl_t nx, exp;
    @(negedge clk);
    instr = it.ins; id_valid = idv; flush = fl; rst = rs;
    #1;
    lu  = m_ex.v && m_ex.res == 2'b01 && m_ex.rd != 5'd0 && idv &&
          ((it.u1 && it.rs1 == m_ex.rd) || (it.u2 && it.rs2 == m_ex.rd));
    stl = !rs && !fl && (m_cnt != 0 || lu);
    check_eq({tag, "_stall"}, 32'(stall), 32'(stl));
    if (rs || fl) begin
      nx = '0; m_cnt = 0;
    end else if (m_cnt != 0) begin
      nx = m_ex; m_cnt--;
    end else if (lu || !idv) begin
      nx = '0;
    end else begin
      nx = it.c;
      if (it.mul) m_cnt = MUL_LAT - 1;
    end
    m_ex = nx;
    sb.push_back(nx);
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check_eq({tag, "_ex"}, 32'(dut_c), 32'(exp));
  endtask

  // Present an instruction until it issues; returns stall cycles seen.
  task automatic feed(input item_t it, input string tag, output int unsigned stalls);
    logic s;
    bit done;
    stalls = 0;
    done = 1'b0;
    for (int k = 0; k < 32 && !done; k++) begin
      step(it, 1'b1, 1'b0, 1'b0, tag, s);
      if (s) stalls++;
      else done = 1'b1;
    end
    if (!done) check_eq({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    item_t       nop, lw5;
    logic        s;
    int unsigned st;
    logic [3:0]  rops [10];
    logic [3:0]  iops [9];
    rops = '{A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND};
    iops = '{A_ADD, A_SLT, A_SLTU, A_XOR, A_OR, A_AND, A_SLL, A_SRL, A_SRA};
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; instr = '0;
    m_ex = '0; m_cnt = 0;
    nop = mk_i(A_ADD, 5'd0, 5'd0, 12'd0);
    lw5 = mk_lw(5'd5, 5'd1, 12'd0);

    step(nop, 1'b0, 1'b0, 1'b1, "reset", s);
    step(nop, 1'b1, 1'b0, 1'b1, "reset_hold", s);

    // addi x5,x6,10
    check_eq("addi_word", mk_i(A_ADD, 5'd5, 5'd6, 12'd10).ins, 32'h00A30293);
    feed(mk_i(A_ADD, 5'd5, 5'd6, 12'd10), "addi", st);

    for (int k = 0; k < 10; k++)
      feed(mk_r(rops[k], 5'(k + 10), 5'(k + 1), 5'(k + 2)), "rtype", st);
    for (int k = 0; k < 9; k++)
      feed(mk_i(iops[k], 5'(k + 20), 5'(k + 3), 12'(k * 37 + 3)), "itype", st);

    feed(mk_lui(5'd8, 20'h12345), "lui", st);
    feed(mk_sw(5'd6, 5'd7, 12'h018), "sw", st);
    feed(mk_br(1'b0, 5'd1, 5'd2), "beq", st);
    feed(mk_br(1'b1, 5'd3, 5'd4), "bne", st);
    feed(mk_jal(5'd1, 20'h00ABC), "jal", st);
    feed(mk_jalr(5'd1, 5'd5, 12'd4), "jalr", st);

    // Load-use: rs1 and rs2 matches stall once, then issue.
    feed(lw5, "lw", st);
    feed(mk_r(A_ADD, 5'd7, 5'd5, 5'd2), "lu_rs1", st);
    check_eq("lu_rs1_cycles", st, 32'd1);
    feed(lw5, "lw", st);
    feed(mk_r(A_ADD, 5'd7, 5'd2, 5'd5), "lu_rs2", st);
    check_eq("lu_rs2_cycles", st, 32'd1);
    feed(lw5, "lw", st);
    feed(mk_sw(5'd5, 5'd3, 12'd0), "lu_sw", st);
    check_eq("lu_sw_cycles", st, 32'd1);
    feed(lw5, "lw", st);
    feed(mk_br(1'b0, 5'd5, 5'd0), "lu_beq", st);
    check_eq("lu_beq_cycles", st, 32'd1);

    // x0 destination and unused-field aliases must not stall.
    feed(mk_lw(5'd0, 5'd1, 12'd0), "lw_x0", st);
    feed(mk_r(A_ADD, 5'd7, 5'd0, 5'd2), "lu_x0", st);
    check_eq("lu_x0_cycles", st, 32'd0);
    feed(lw5, "lw", st);
    feed(mk_i(A_ADD, 5'd6, 5'd1, 12'd5), "lu_irs2", st);
    check_eq("lu_irs2_cycles", st, 32'd0);
    feed(lw5, "lw", st);
    feed(mk_lui(5'd8, 20'h00028), "lu_lui", st);
    check_eq("lu_lui_cycles", st, 32'd0);
    feed(lw5, "lw", st);
    feed(mk_jal(5'd9, 20'h00528), "lu_jal", st);
    check_eq("lu_jal_cycles", st, 32'd0);

    // id_valid low: bubble, no stall even with matching fields.
    feed(lw5, "lw", st);
    step(mk_r(A_ADD, 5'd7, 5'd5, 5'd2), 1'b0, 1'b0, 1'b0, "novalid", s);
    feed(nop, "nop", st);

    // Flush together with a load-use hazard.
    feed(lw5, "lw", st);
    step(mk_r(A_ADD, 5'd7, 5'd5, 5'd2), 1'b1, 1'b1, 1'b0, "flush_lu", s);
    check_eq("flush_lu_nostall", 32'(s), 32'd0);
    feed(mk_r(A_ADD, 5'd7, 5'd5, 5'd2), "after_flush", st);

    // Reset during a load-use stall, then normal issue.
    feed(lw5, "lw", st);
    step(mk_r(A_ADD, 5'd7, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, "rst_lu", s);
    feed(mk_r(A_ADD, 5'd7, 5'd5, 5'd2), "after_rst", st);
    check_eq("after_rst_cycles", st, 32'd0);

    // Illegal encodings: one-cycle ex_illegal bubble.
    feed(mk_bad(32'h0000007F), "ill_7f", st);
    feed(nop, "ill_clear", st);
    feed(mk_bad({12'd0, 5'd1, 3'b000, 5'd5, 7'b0000011}), "ill_lb", st);
    feed(mk_bad({7'd0, 5'd2, 5'd1, 3'b100, 5'd0, 7'b1100011}), "ill_blt", st);
    feed(mk_bad({7'b0000001, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0110011}), "ill_div", st);
    feed(nop, "nop", st);

`ifdef CTRL_MULDIV_EN
    // Multiply: issue, then three stalled cycles holding ID/EX.
    feed(mk_mul(5'd3, 5'd1, 5'd2), "mul", st);
    feed(mk_r(A_ADD, 5'd9, 5'd1, 5'd2), "mul_wait", st);
    check_eq("mul_stall_cycles", st, 32'(MUL_LAT - 1));
    // Reset in the second cycle of the busy window.
    feed(mk_mul(5'd3, 5'd1, 5'd2), "mul", st);
    step(nop, 1'b1, 1'b0, 1'b0, "mul_busy", s);
    step(nop, 1'b1, 1'b0, 1'b1, "mul_rst", s);
    feed(mk_r(A_ADD, 5'd9, 5'd1, 5'd2), "mul_after_rst", st);
    check_eq("mul_after_rst_cycles", st, 32'd0);
    // Flush clears the busy counter.
    feed(mk_mul(5'd3, 5'd1, 5'd2), "mul", st);
    step(nop, 1'b1, 1'b1, 1'b0, "mul_flush", s);
    feed(mk_r(A_ADD, 5'd9, 5'd1, 5'd2), "mul_after_flush", st);
    check_eq("mul_after_flush_cycles", st, 32'd0);
`else
    feed(mk_mul(5'd3, 5'd1, 5'd2), "mul_ill", st);
    feed(nop, "nop", st);
`endif

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
